// File: rtl/snn_enc_pkg.sv
// Shared types and constants for the spike rate encoder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package snn_enc_pkg;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } enc_state_t;

    // x^16 + x^14 + x^13 + x^11 + 1 as a left-shifting Fibonacci register:
    // feedback taps are state bits 15, 13, 12 and 10.
    localparam int                LFSR_W    = 16;
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

    // Per-channel offset multiplier so channels sharing one LFSR draw
    // different thresholds in the same step.
    localparam int CH_DECOR = 37;

    // One LFSR advance: shift left, parity of the tapped bits enters at bit 0.
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] l);
        return {l[LFSR_W-2:0], ^(l & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR, reloads SEED on reset and advances when enabled.
// Latency: new value visible the cycle after en_i is sampled high.
// Backpressure: none; en_i is the only pacing control.
module lfsr16
    import snn_enc_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    output logic [LFSR_W-1:0] state_o
);

    // Shift register: reload seed on reset, otherwise step only when enabled.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_o <= SEED;
        end else if (en_i) begin
            state_o <= lfsr_step(state_o);
        end
    end

endmodule

// File: rtl/spike_rate_encoder.sv
// Buffers NUM_CH serial pixels, then emits NUM_STEPS Bernoulli spike vectors and a done pulse.
// Latency: first spike vector one cycle after the last pixel handshake; all outputs registered.
// Backpressure: pix_ready_o low outside LOAD; spike side has none, consumer takes every step.
module spike_rate_encoder
    import snn_enc_pkg::*;
#(
    parameter int          NUM_CH    = 8,
    parameter int          WIDTH_P   = 8,
    parameter int          NUM_STEPS = 16,
    parameter logic [15:0] SEED      = 16'hACE1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               pix_valid_i,
    input  logic [WIDTH_P-1:0] pix_data_i,
    output logic               pix_ready_o,
    output logic               spike_valid_o,
    output logic [NUM_CH-1:0]  spike_o,
    output logic [7:0]         step_o,
    output logic               frame_done_o
);

    localparam int                 CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CH_W-1:0]    LAST_CH   = CH_W'(NUM_CH - 1);
    localparam logic [7:0]         LAST_STEP = 8'(NUM_STEPS - 1);
    localparam logic [WIDTH_P-1:0] PIX_MAX   = '1;

    enc_state_t         state;
    enc_state_t         state_nxt;
    logic [CH_W-1:0]    ch;
    logic [WIDTH_P-1:0] pix_buf [NUM_CH];
    logic [LFSR_W-1:0]  lfsr;
    logic [WIDTH_P-1:0] rnd_base;
    logic [7:0]         step_nxt;
    logic [NUM_CH-1:0]  spike_nxt;
    logic               pix_hs;

    // pix_ready_o is high exactly in LOAD, so it doubles as the accept gate.
    assign pix_hs = pix_valid_i & pix_ready_o;

    lfsr16 #(
        .SEED (SEED)
    ) u_lfsr (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .en_i    (state == RUN),
        .state_o (lfsr)
    );

    // Outputs are registered, so spikes are computed from the LFSR value the
    // next cycle will hold: current value when entering RUN, stepped value
    // while staying in RUN.
    always_comb begin
        rnd_base = WIDTH_P'((state == RUN) ? lfsr_step(lfsr) : lfsr);
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and next timestep index.
    always_comb begin
        state_nxt = state;
        step_nxt  = 8'd0;
        unique case (state)
            LOAD: begin
                if (pix_hs && (ch == LAST_CH)) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (step_o == LAST_STEP) begin
                    state_nxt = DONE;
                end else begin
                    state_nxt = RUN;
                    step_nxt  = step_o + 8'd1;
                end
            end
            DONE: begin
                state_nxt = LOAD;
            end
            default: begin
                state_nxt = LOAD;
            end
        endcase
    end

    // One comparator per channel; the pixel arriving this cycle bypasses the
    // buffer so the last channel is usable in the very next (first RUN) cycle.
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        localparam int unsigned        DECOR_I = (c * CH_DECOR) % (1 << WIDTH_P);
        localparam logic [WIDTH_P-1:0] DECOR   = WIDTH_P'(DECOR_I);

        logic [WIDTH_P-1:0] pix_cur;
        logic [WIDTH_P-1:0] rnd;

        assign pix_cur      = (pix_hs && (ch == CH_W'(c))) ? pix_data_i : pix_buf[c];
        assign rnd          = rnd_base ^ DECOR;
        assign spike_nxt[c] = (pix_cur == PIX_MAX) || (pix_cur > rnd);
    end

    // Pixel buffer: store each accepted pixel at the current channel slot.
    always_ff @(posedge clk_i) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (rst_i) begin
                pix_buf[c] <= '0;
            end else if (pix_hs && (ch == CH_W'(c))) begin
                pix_buf[c] <= pix_data_i;
            end
        end
    end

    // Channel counter and registered outputs, all derived from the next state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ch            <= '0;
            pix_ready_o   <= 1'b1;
            spike_valid_o <= 1'b0;
            spike_o       <= '0;
            step_o        <= 8'd0;
            frame_done_o  <= 1'b0;
        end else begin
            if (pix_hs) begin
                ch <= (ch == LAST_CH) ? '0 : ch + CH_W'(1);
            end
            pix_ready_o   <= (state_nxt == LOAD);
            spike_valid_o <= (state_nxt == RUN);
            spike_o       <= (state_nxt == RUN) ? spike_nxt : '0;
            step_o        <= step_nxt;
            frame_done_o  <= (state_nxt == DONE);
        end
    end

endmodule

// File: tb/tb_spike_rate_encoder.sv
// Directed bench for spike_rate_encoder with a bit-level reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_spike_rate_encoder;

    typedef logic [7:0][7:0] pix_vec_t;
    localparam logic [15:0] SEED = 16'hACE1;

    logic       clk         = 1'b0;
    logic       rst_i       = 1'b1;
    logic       pix_valid_i = 1'b0;
    logic [7:0] pix_data_i  = 8'd0;
    logic       pix_ready_o;
    logic       spike_valid_o;
    logic [7:0] spike_o;
    logic [7:0] step_o;
    logic       frame_done_o;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] model_l  = SEED;

    spike_rate_encoder #(
        .NUM_CH    (8),
        .WIDTH_P   (8),
        .NUM_STEPS (16),
        .SEED      (SEED)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .pix_valid_i   (pix_valid_i),
        .pix_data_i    (pix_data_i),
        .pix_ready_o   (pix_ready_o),
        .spike_valid_o (spike_valid_o),
        .spike_o       (spike_o),
        .step_o        (step_o),
        .frame_done_o  (frame_done_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_adv(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    function automatic logic [7:0] model_spikes(input pix_vec_t p, input logic [15:0] l);
        logic [7:0]  s;
        logic [7:0]  r;
        int unsigned d;
        for (int c = 0; c < 8; c++) begin
            d    = (c * 37) % 256;
            r    = l[7:0] ^ d[7:0];
            s[c] = (p[c] == 8'hFF) || (p[c] > r);
        end
        return s;
    endfunction

    // Every task below ends one time unit after a rising edge.
    task automatic do_reset();
        @(posedge clk);
        #1 rst_i = 1'b1;
        pix_valid_i = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_i = 1'b0;
        model_l = SEED;
    endtask

    task automatic send_pixel(input logic [7:0] d);
        int n;
        n = 0;
        pix_valid_i = 1'b1;
        pix_data_i  = d;
        @(negedge clk);
        while (!pix_ready_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("ready_timeout", 32'(pix_ready_o), 32'd1);
        check("load_no_spike", 32'(spike_valid_o), 32'd0);
        @(posedge clk);
        #1 pix_valid_i = 1'b0;
    endtask

    task automatic load_frame(input pix_vec_t p, input bit gaps);
        for (int i = 0; i < 8; i++) begin
            send_pixel(p[i]);
            if (gaps && i < 7) begin
                @(negedge clk);
                check("gap_no_spike", 32'(spike_valid_o), 32'd0);
                check("gap_ready", 32'(pix_ready_o), 32'd1);
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic check_run(input string tag, input pix_vec_t p, input logic [15:0] mask_en,
                             input logic [15:0][7:0] masks, output logic [7:0][7:0] cnt);
        cnt = '0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            check({tag, "_vld"}, 32'(spike_valid_o), 32'd1);
            check({tag, "_step"}, 32'(step_o), 32'(k));
            check({tag, "_spk"}, 32'(spike_o), 32'(model_spikes(p, model_l)));
            if (mask_en[k]) check({tag, "_mask"}, 32'(spike_o), 32'(masks[k]));
            check({tag, "_nodone"}, 32'(frame_done_o), 32'd0);
            for (int c = 0; c < 8; c++) if (spike_o[c]) cnt[c] = cnt[c] + 8'd1;
            model_l = lfsr_adv(model_l);
        end
        @(negedge clk);
        check({tag, "_done"}, 32'(frame_done_o), 32'd1);
        check({tag, "_done_vld"}, 32'(spike_valid_o), 32'd0);
        check({tag, "_done_spk"}, 32'(spike_o), 32'd0);
        check({tag, "_done_step"}, 32'(step_o), 32'd0);
        check({tag, "_done_rdy"}, 32'(pix_ready_o), 32'd0);
        @(negedge clk);
        check({tag, "_post_done"}, 32'(frame_done_o), 32'd0);
        check({tag, "_post_rdy"}, 32'(pix_ready_o), 32'd1);
        check({tag, "_post_vld"}, 32'(spike_valid_o), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        pix_vec_t          p;
        pix_vec_t          fp;
        logic [15:0][7:0]  masks;
        logic [7:0][7:0]   cnt;
        int                acc;
        int                frames;
        int                k;
        int                n_done;
        logic              hs;

        // Reset, then idle
        do_reset();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_vld", 32'(spike_valid_o), 32'd0);
            check("idle_rdy", 32'(pix_ready_o), 32'd1);
            check("idle_done", 32'(frame_done_o), 32'd0);
            check("idle_spk", 32'(spike_o), 32'd0);
            check("idle_step", 32'(step_o), 32'd0);
        end
        @(posedge clk);
        #1;

        // Alternating 0/255 pixels: odd channels always fire, even never
        for (int i = 0; i < 8; i++) p[i] = (i % 2 == 1) ? 8'd255 : 8'd0;
        for (int i = 0; i < 16; i++) masks[i] = 8'hAA;
        load_frame(p, 1'b0);
        check_run("alt", p, 16'hFFFF, masks, cnt);

        // All 128 from a fresh seed; first 8 steps hand-derived from seed bit 7
        do_reset();
        for (int i = 0; i < 8; i++) p[i] = 8'd128;
        masks    = '0;
        masks[0] = 8'h70; masks[1] = 8'h70; masks[2] = 8'h70; masks[3] = 8'h8F;
        masks[4] = 8'h8F; masks[5] = 8'h8F; masks[6] = 8'h8F; masks[7] = 8'h70;
        load_frame(p, 1'b0);
        check_run("half", p, 16'h00FF, masks, cnt);
        for (int c = 0; c < 8; c++)
            check("half_rate", 32'(cnt[c] >= 8'd4 && cnt[c] <= 8'd12), 32'd1);

        // Valid held high with incrementing data across two frames
        do_reset();
        pix_valid_i = 1'b1;
        pix_data_i  = 8'd120;
        acc = 0; frames = 0; k = 0;
        for (int cyc = 0; cyc < 200 && frames < 2; cyc++) begin
            @(negedge clk);
            hs = pix_ready_o;
            if (spike_valid_o) begin
                for (int c = 0; c < 8; c++) fp[c] = 8'(120 + 8 * frames + c);
                check("held_step", 32'(step_o), 32'(k));
                check("held_spk", 32'(spike_o), 32'(model_spikes(fp, model_l)));
                model_l = lfsr_adv(model_l);
                k++;
            end
            if (frame_done_o) begin
                check("held_accepted", 32'(acc), 32'd8);
                check("held_steps", 32'(k), 32'd16);
                acc = 0;
                k   = 0;
                frames++;
            end
            @(posedge clk);
            #1;
            if (hs) begin
                acc++;
                pix_data_i = pix_data_i + 8'd1;
            end
        end
        check("held_frames", 32'(frames), 32'd2);
        pix_valid_i = 1'b0;

        // Reset during RUN step 5
        do_reset();
        for (int i = 0; i < 8; i++) p[i] = (i % 2 == 1) ? 8'd255 : 8'd0;
        load_frame(p, 1'b0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("pre_rst_step", 32'(step_o), 32'(i));
        end
        rst_i = 1'b1;
        @(posedge clk);
        #1 rst_i = 1'b0;
        model_l = SEED;
        @(negedge clk);
        check("rst_vld", 32'(spike_valid_o), 32'd0);
        check("rst_step", 32'(step_o), 32'd0);
        check("rst_rdy", 32'(pix_ready_o), 32'd1);
        check("rst_spk", 32'(spike_o), 32'd0);
        n_done = 0;
        for (int i = 0; i < 20; i++) begin
            if (frame_done_o) n_done++;
            @(negedge clk);
        end
        check("rst_no_done", 32'(n_done), 32'd0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) p[i] = 8'd255;
        for (int i = 0; i < 16; i++) masks[i] = 8'hFF;
        load_frame(p, 1'b0);
        check_run("full", p, 16'hFFFF, masks, cnt);

        // Same mixed frame with and without gaps, each from a fresh seed
        p[0] = 8'd10;  p[1] = 8'd50; p[2] = 8'd100; p[3] = 8'd128;
        p[4] = 8'd200; p[5] = 8'd30; p[6] = 8'd255; p[7] = 8'd0;
        do_reset();
        load_frame(p, 1'b0);
        check_run("mix", p, 16'h0000, masks, cnt);
        do_reset();
        load_frame(p, 1'b1);
        check_run("mix_gap", p, 16'h0000, masks, cnt);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
